// File: rtl/hs_mem_sync_fifo.sv
// hs_mem_sync_fifo -- single-clock FIFO built around a simple dual-port RAM.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; stored items are discarded at once
//   s_data   write-side item        s_valid  item present     s_ready  can accept
//   m_data   read-side item (RAM rdata register)
//   m_valid  m_data holds an item   m_ready  consumer accepts m_data
//   count    occupancy: items in RAM plus the one held on m_data (0..DATA_DEPTH+1)
//
// The RAM's registered read port is the output holding stage. An item therefore
// lives either in the RAM (ram_cnt) or on m_data (m_valid), and reads are issued
// only when the holding stage is free or being emptied on this edge.

// Simple dual-port RAM: one write port, one registered read port.
// rdata keeps its value while ren=0, which is how m_data stays stable on stall.
module hs_mem_sdpram #(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    parameter int  ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  DATA_TYPE              wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output DATA_TYPE              rdata
);
    DATA_TYPE mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
        if (ren)
            rdata <= mem[raddr];
    end
endmodule

module hs_mem_sync_fifo #(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
    localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  DATA_TYPE             s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output DATA_TYPE             m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] count
);
    generate
        if (DATA_DEPTH < 2 || DATA_DEPTH > 1048576 ||
            (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("hs_mem_sync_fifo: DATA_DEPTH must be a power of two in 2..1048576");
        end
    endgenerate

    typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_WIDTH-1:0]  ram_cnt;
    logic                  push;
    logic                  ren;

    // Full is judged on registered ram_cnt alone, so a pop in the same cycle
    // cannot open a slot until the next cycle.
    assign s_ready = (ram_cnt < CNT_WIDTH'(DATA_DEPTH));
    assign push    = s_valid & s_ready;
    // Refill the holding stage when it is empty or being consumed this edge.
    assign ren     = (ram_cnt != '0) & (~m_valid | m_ready);
    assign count   = ram_cnt + CNT_WIDTH'(m_valid);

    hs_mem_sdpram #(
        .DATA_TYPE  (DATA_TYPE),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .wen   (push),
        .waddr (wptr),
        .wdata (s_data),
        .ren   (ren),
        .raddr (rptr),
        .rdata (m_data)
    );

    // Pointers wrap naturally: DATA_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
        end else begin
            if (push)
                wptr <= wptr + ADDR_WIDTH'(1);
            if (ren)
                rptr <= rptr + ADDR_WIDTH'(1);
            case ({push, ren})
                2'b10:   ram_cnt <= ram_cnt + CNT_WIDTH'(1);
                2'b01:   ram_cnt <= ram_cnt - CNT_WIDTH'(1);
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    // Output stage: VALID whenever rdata holds an item not yet accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (ren) begin
                    state   <= VALID;
                    m_valid <= 1'b1;
                end
                VALID: if (m_ready && !ren) begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                end
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // ram_cnt==0 implies rptr==wptr with no read; ram_cnt==DATA_DEPTH implies
    // the same pointers with no write, so a collision means broken bookkeeping.
    a_no_rw_collision: assert property (@(posedge clk) disable iff (rst)
        !(push && ren && (wptr == rptr)));
`endif
endmodule

// File: doc/hs_mem_sync_fifo.md
HS_MEM_SYNC_FIFO -- requirements
Module: hs_mem_sync_fifo

Interface
REQ-001 Parameter DATA_TYPE, default logic[7:0]: item type stored in the FIFO.
REQ-002 Parameter DATA_DEPTH, default 16: RAM entries; legal values are powers of two from 2 to 1048576; any other value SHALL be rejected by an elaboration-time assertion.
REQ-003 Local parameter ADDR_WIDTH = $clog2(DATA_DEPTH); local parameter CNT_WIDTH = $clog2(DATA_DEPTH+2).
REQ-004 clk  input  1  single clock; all logic SHALL sample on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_data  input  DATA_TYPE  write-side item.
REQ-007 s_valid  input  1  write-side item present.
REQ-008 s_ready  output  1  FIFO can accept an item.
REQ-009 m_data  output  DATA_TYPE  read-side item.
REQ-010 m_valid  output  1  m_data holds a valid item.
REQ-011 m_ready  input  1  consumer accepts m_data.
REQ-012 count  output  CNT_WIDTH  total occupancy, from 0 to DATA_DEPTH+1.

Function
REQ-013 Storage SHALL be one hs_mem_sdpram instance (DATA_TYPE, DATA_DEPTH); m_data SHALL be driven directly by its rdata, which is the output holding stage.
REQ-014 A push occurs when s_valid & s_ready; it SHALL drive wen=1, waddr=wptr, wdata=s_data, and increment wptr modulo DATA_DEPTH.
REQ-015 ram_cnt is an internal counter of the entries written but not yet read; it SHALL increase by 1 on a push and decrease by 1 on a RAM read, and stay unchanged when both or neither occur.
REQ-016 s_ready SHALL equal (ram_cnt < DATA_DEPTH), taken from registered state only, with no combinational path from m_ready or s_valid.
REQ-017 A RAM read SHALL be issued (ren=1, raddr=rptr, rptr incremented modulo DATA_DEPTH) when ram_cnt > 0 and (m_valid == 0 or m_ready == 1).
REQ-018 Output state machine: EMPTY (m_valid=0) and VALID (m_valid=1).
- EMPTY -> VALID on the edge at which a read is issued.
- VALID -> EMPTY on the edge at which m_ready=1 and no read is issued.
- In all other cases the state SHALL be held.
REQ-019 While m_valid=1 and m_ready=0, m_data SHALL remain stable (ren=0 keeps rdata held).
REQ-020 count SHALL equal ram_cnt + m_valid; it SHALL be registered or derived from registered state only.
REQ-021 Latency: an item pushed in cycle t SHALL appear with m_valid=1 in cycle t+2 when the FIFO was empty.
REQ-022 Throughput: with s_valid=1 and m_ready=1 held continuously, one item SHALL be accepted and one delivered every cycle after the initial latency, with no bubbles.
REQ-023 Full boundary: at ram_cnt == DATA_DEPTH a push SHALL be refused even if a pop occurs in the same cycle; s_ready SHALL rise on the following cycle.
REQ-024 Empty boundary: m_ready asserted while m_valid=0 SHALL have no effect.
REQ-025 Ordering: items SHALL be delivered in push order, without loss or duplication.
REQ-026 A read and a write to the same RAM address SHALL never occur in the same cycle; this follows from REQ-016 and REQ-017 and SHALL be checked by an assertion.
REQ-027 Pointer wrap from DATA_DEPTH-1 to 0 SHALL be seamless.

Reset
REQ-028 While rst=1, asynchronously: wptr=0, rptr=0, ram_cnt=0, m_valid=0, count=0.
REQ-029 s_ready SHALL be 1 from the first rising edge after rst deasserts.
REQ-030 m_data is don't-care while m_valid=0; RAM contents are not cleared.
REQ-031 rst asserted mid-operation SHALL discard all stored items immediately, without waiting for a clock edge.

Verification (DATA_DEPTH=4, DATA_TYPE=logic[7:0])
REQ-032 Single item: reset, then push 0xA5 in cycle 0 -> m_valid=1 and m_data=0xA5 in cycle 2, count=1; pop -> count=0 and m_valid=0.
REQ-033 Fill: m_ready=0, offer 0x01..0x06 back-to-back -> exactly 0x01..0x05 accepted, s_ready=0, count=5, m_data=0x01 held stable.
REQ-034 Drain: from the full state of REQ-033, m_ready=1 -> 0x01..0x05 delivered in five consecutive cycles, then m_valid=0, count=0.
REQ-035 Streaming: s_valid=1 and m_ready=1 for 100 cycles with data 0..99 -> output 0..99 in order, one per cycle, count steady at 2, with at least 25 pointer wraps.
REQ-036 Full with simultaneous pop: count=5, s_valid=1, m_ready=1 -> no push that cycle; s_ready=1 and count=4 on the next cycle.
REQ-037 Asynchronous reset: at count=3, pulse rst between clock edges -> count=0 and m_valid=0 without a clock edge; a subsequent push of 0x3C appears 2 cycles later.
